// File: rtl/relu_mac_layer_1.sv
`default_nettype none
// ============================================================================
// Module  : relu_mac_layer_1
// Brief   : Second fully-connected stage: ReLU on inputs, bias + weighted sum
//           per output, one shared signed multiplier, valid/ready on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module relu_mac_layer_1 #(
    parameter int IN_N   = 2,
    parameter int OUT_N  = 2,
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter logic [OUT_N*IN_N*DATA_W-1:0] WEIGHTS = 64'h0040_0080_FF00_0100,
    parameter logic [OUT_N*DATA_W-1:0]      BIAS    = 32'h0100_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_N*DATA_W-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_N*DATA_W-1:0]   out_data,
    output logic                      busy
);

    localparam int ACC_W = 2*DATA_W + $clog2(IN_N) + 1;
    localparam int IW    = (IN_N  > 1) ? $clog2(IN_N)  : 1;
    localparam int OW    = (OUT_N > 1) ? $clog2(OUT_N) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(IN_N - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUT_N - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W-1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [IW-1:0]              i_q, i_d;
    logic [OW-1:0]              o_q, o_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [DATA_W-1:0]   x_q [IN_N];
    logic signed [DATA_W-1:0]   x_d [IN_N];
    logic [DATA_W-1:0]          y_q [OUT_N];
    logic [DATA_W-1:0]          y_d [OUT_N];

    logic signed [DATA_W-1:0]   w_arr [OUT_N][IN_N];
    logic signed [DATA_W-1:0]   w_x;
    logic signed [DATA_W-1:0]   w_w;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_sum;
    logic signed [ACC_W-1:0]    w_y;
    logic [DATA_W-1:0]          w_sat;

    // Bias pre-scaled into accumulator fixed-point format.
    function automatic logic signed [ACC_W-1:0] bias_acc(input int idx);
        logic [DATA_W-1:0] b;
        logic [ACC_W-1:0]  ext;
        b   = BIAS[idx*DATA_W +: DATA_W];
        ext = {{(ACC_W-DATA_W){b[DATA_W-1]}}, b};
        return ext << FRAC;
    endfunction

    generate
        for (genvar go = 0; go < OUT_N; go++) begin : g_wo
            for (genvar gi = 0; gi < IN_N; gi++) begin : g_wi
                assign w_arr[go][gi] = WEIGHTS[(go*IN_N+gi)*DATA_W +: DATA_W];
            end
        end
        for (genvar go = 0; go < OUT_N; go++) begin : g_out
            assign out_data[go*DATA_W +: DATA_W] = y_q[go];
        end
    endgenerate

    assign w_x    = x_q[i_q];
    assign w_w    = w_arr[o_q][i_q];
    assign w_prod = w_x * w_w;
    assign w_sum  = acc_q + {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_y    = w_sum >>> FRAC;

    always_comb begin
        w_sat = w_y[DATA_W-1:0];
        if (w_y > SAT_MAX) begin
            w_sat = SAT_MAX[DATA_W-1:0];
        end else if (w_y < SAT_MIN) begin
            w_sat = SAT_MIN[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        o_d     = o_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int k = 0; k < IN_N; k++) begin
                        x_d[k] = in_data[k*DATA_W + DATA_W - 1] ? '0
                                                                : in_data[k*DATA_W +: DATA_W];
                    end
                    i_d     = '0;
                    o_d     = '0;
                    acc_d   = bias_acc(0);
                    state_d = MAC;
                end
            end
            MAC: begin
                if (i_q == I_LAST) begin
                    y_d[o_q] = w_sat;
                    i_d      = '0;
                    if (o_q == O_LAST) begin
                        o_d     = '0;
                        acc_d   = '0;
                        state_d = HOLD;
                    end else begin
                        o_d   = o_q + OW'(1);
                        acc_d = bias_acc(int'(o_q) + 1);
                    end
                end else begin
                    i_d   = i_q + IW'(1);
                    acc_d = w_sum;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            o_q     <= '0;
            acc_q   <= '0;
            for (int k = 0; k < IN_N; k++) begin
                x_q[k] <= '0;
            end
            for (int k = 0; k < OUT_N; k++) begin
                y_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            o_q     <= o_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q == MAC);

endmodule
`default_nettype wire

// File: tb/tb_relu_mac_layer_1.sv
`default_nettype none
// ============================================================================
// Module  : tb_relu_mac_layer_1
// Brief   : Self-checking bench for relu_mac_layer_1 with a fixed-point model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_relu_mac_layer_1;

    localparam logic [63:0] W_A = 64'h0040_0080_FF00_0100;
    localparam logic [31:0] B_A = 32'h0100_0000;
    localparam logic [63:0] W_B = {4{16'h0400}};
    localparam logic [63:0] W_C = {4{16'hFC00}};
    localparam logic [31:0] B_Z = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;

    logic        in_ready_a, out_valid_a, busy_a;
    logic        in_ready_b, out_valid_b, busy_b;
    logic        in_ready_c, out_valid_c, busy_c;
    logic [31:0] out_data_a, out_data_b, out_data_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    relu_mac_layer_1 dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_data(out_data_a), .busy(busy_a)
    );

    relu_mac_layer_1 #(.WEIGHTS(W_B), .BIAS(B_Z)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_data(out_data_b), .busy(busy_b)
    );

    relu_mac_layer_1 #(.WEIGHTS(W_C), .BIAS(B_Z)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data), .out_valid(out_valid_c), .out_ready(out_ready),
        .out_data(out_data_c), .busy(busy_c)
    );

    // Real-valued layer computed on integers scaled by 256, floored, clamped.
    function automatic logic [31:0] model(input logic [31:0] din,
                                          input logic [63:0] w,
                                          input logic [31:0] b);
        logic [31:0]       r;
        logic signed [15:0] t;
        longint            acc, xv, y;
        r = '0;
        for (int o = 0; o < 2; o++) begin
            t   = b[o*16 +: 16];
            acc = longint'(t) * 256;
            for (int i = 0; i < 2; i++) begin
                t  = din[i*16 +: 16];
                xv = (t < 0) ? 64'sd0 : longint'(t);
                t  = w[(o*2+i)*16 +: 16];
                acc = acc + xv * longint'(t);
            end
            if (acc >= 0) y = acc / 256;
            else          y = -((-acc + 255) / 256);
            if (y > 32767)       y = 32767;
            else if (y < -32768) y = -32768;
            r[o*16 +: 16] = y[15:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_vec();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 3) == 0) v[15:0]  = 16'h4000 + 16'($urandom_range(0, 16'h3FFF));
        return v;
    endfunction

    task automatic do_vector(input logic [31:0] din, input string tag);
        int          lat;
        logic [31:0] ea, eb, ec;
        ea = model(din, W_A, B_A);
        eb = model(din, W_B, B_Z);
        ec = model(din, W_C, B_Z);
        lat = 0;
        while (!in_ready_a && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        n_cmp++;
        if (in_ready_a !== 1'b1) begin
            n_err++; $display("FAIL %s in_ready got %b exp 1", tag, in_ready_a);
        end
        in_data = din; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid_a && lat < 20) begin
            n_cmp++;
            if (busy_a !== 1'b1) begin
                n_err++; $display("FAIL %s busy got %b exp 1 at cycle %0d", tag, busy_a, lat);
            end
            @(posedge clk); #1; lat++;
        end
        n_cmp++;
        if (lat !== 4) begin
            n_err++; $display("FAIL %s latency got %0d exp 4", tag, lat);
        end
        n_cmp++;
        if (out_data_a !== ea) begin
            n_err++; $display("FAIL %s data_a got %h exp %h", tag, out_data_a, ea);
        end
        n_cmp++;
        if (out_data_b !== eb || out_valid_b !== 1'b1) begin
            n_err++; $display("FAIL %s data_b got %h/%b exp %h/1", tag, out_data_b, out_valid_b, eb);
        end
        n_cmp++;
        if (out_data_c !== ec || out_valid_c !== 1'b1) begin
            n_err++; $display("FAIL %s data_c got %h/%b exp %h/1", tag, out_data_c, out_valid_c, ec);
        end
        n_cmp++;
        if (busy_a !== 1'b0 || in_ready_a !== 1'b0) begin
            n_err++; $display("FAIL %s hold busy/in_ready got %b/%b exp 0/0", tag, busy_a, in_ready_a);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || out_data_a !== ea) begin
            n_err++;
            $display("FAIL %s post-handshake in_ready/out_valid/data got %b/%b/%h exp 1/0/%h",
                     tag, in_ready_a, out_valid_a, out_data_a, ea);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({in_ready_a, in_ready_b, in_ready_c} !== 3'b111) begin
            n_err++; $display("FAIL reset in_ready got %b exp 111", {in_ready_a, in_ready_b, in_ready_c});
        end
        n_cmp++;
        if ({out_valid_a, out_valid_b, out_valid_c, busy_a, busy_b, busy_c} !== 6'b0) begin
            n_err++; $display("FAIL reset valid/busy got %b exp 000000",
                              {out_valid_a, out_valid_b, out_valid_c, busy_a, busy_b, busy_c});
        end
        n_cmp++;
        if (out_data_a !== 32'h0 || out_data_b !== 32'h0 || out_data_c !== 32'h0) begin
            n_err++; $display("FAIL reset out_data got %h/%h/%h exp 0", out_data_a, out_data_b, out_data_c);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        do_vector(32'h0100_0200, "basic");
        n_cmp++;
        if (out_data_a !== 32'h0240_0100) begin
            n_err++; $display("FAIL basic_literal got %h exp 02400100", out_data_a);
        end
        do_vector(32'h0200_FD00, "relu");
        n_cmp++;
        if (out_data_a !== 32'h0180_FE00) begin
            n_err++; $display("FAIL relu_literal got %h exp 0180fe00", out_data_a);
        end
        do_vector(32'h0000_4000, "sat");
        n_cmp++;
        if (out_data_b !== 32'h7FFF_7FFF || out_data_c !== 32'h8000_8000) begin
            n_err++; $display("FAIL sat_literal got %h/%h exp 7fff7fff/80008000", out_data_b, out_data_c);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            do_vector(rand_vec(), "random");
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] din, ea;
        int          lat;
        din = rand_vec();
        ea  = model(din, W_A, B_A);
        in_data = din; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid_a && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        n_cmp++;
        if (out_valid_a !== 1'b1) begin
            n_err++; $display("FAIL bp_wait out_valid got %b exp 1", out_valid_a);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_data  = $urandom;
            @(posedge clk); #1;
            n_cmp++;
            if (out_data_a !== ea || out_valid_a !== 1'b1 || in_ready_a !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cyc %0d data/valid/in_ready got %h/%b/%b exp %h/1/0",
                         c, out_data_a, out_valid_a, in_ready_a, ea);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
            n_err++; $display("FAIL bp_release in_ready/out_valid got %b/%b exp 1/0", in_ready_a, out_valid_a);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (busy_a !== 1'b0 || out_data_a !== ea) begin
            n_err++; $display("FAIL bp_ignored busy/data got %b/%h exp 0/%h", busy_a, out_data_a, ea);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va, vb, cur, exp_q[$], ev;
        int          last, outs;
        logic        acc_now;
        va = rand_vec(); vb = rand_vec();
        cur = va; last = -1; outs = 0;
        in_data = cur; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc_now = in_ready_a;
            if (acc_now) exp_q.push_back(model(cur, W_A, B_A));
            if (out_valid_a) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL b2b unexpected output %h at cycle %0d", out_data_a, cyc);
                end else begin
                    ev = exp_q.pop_front();
                    if (out_data_a !== ev) begin
                        n_err++; $display("FAIL b2b data got %h exp %h", out_data_a, ev);
                    end
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last != 6) begin
                        n_err++; $display("FAIL b2b spacing got %0d exp 6", cyc - last);
                    end
                end
                last = cyc; outs++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                cur = (cur == va) ? vb : va;
                in_data = cur;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (outs < 6) begin
            n_err++; $display("FAIL b2b output count got %0d exp >=6", outs);
        end
        for (int k = 0; k < 20 && !in_ready_a; k++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        in_data = rand_vec(); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid_a !== 1'b0 || out_data_a !== 32'h0 || in_ready_a !== 1'b1 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid valid/data/in_ready/busy got %b/%h/%b/%b exp 0/0/1/0",
                     out_valid_a, out_data_a, in_ready_a, busy_a);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (out_valid_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL rst_replay activity cycles got %0d exp 0", bad);
        end
        do_vector(32'h0100_0200, "after_reset");
        n_cmp++;
        if (out_data_a !== 32'h0240_0100) begin
            n_err++; $display("FAIL after_reset_literal got %h exp 02400100", out_data_a);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
